// File: rtl/endian_swapper_pkg.sv
// endian_swapper_pkg: shared scheduler states and swapper CSR map.
package endian_swapper_pkg;
  typedef enum logic [1:0] {IDLE, CFG, PASS} sched_state_t;
  localparam logic [1:0] CSR_ADDR_CTRL      = 2'd0;
  localparam logic [1:0] CSR_ADDR_PKT_COUNT = 2'd1;
  localparam int         CSR_CTRL_SWAP_BIT  = 0;
endpackage

// File: rtl/endian_swapper_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         any
);
  logic [W:0] idx;
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (W+1)'(i);
      idx = (idx >= (W+1)'(N)) ? idx - (W+1)'(N) : idx;
      if (!any && req[idx[W-1:0]]) begin
        any              = 1'b1;
        gnt_id           = idx[W-1:0];
        gnt[idx[W-1:0]]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/endian_swapper_scheduler.sv
// endian_swapper_scheduler: packet-atomic round-robin sharing of one endian swapper,
// reprogramming the swapper's byteswap mode over CSR before a mode-mismatched grant.
module endian_swapper_scheduler
  import endian_swapper_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]       in_data,
  input  logic [NUM_PORTS*$clog2(DATA_BYTES)-1:0] in_empty,
  input  logic [NUM_PORTS-1:0]                    in_valid,
  input  logic [NUM_PORTS-1:0]                    in_startofpacket,
  input  logic [NUM_PORTS-1:0]                    in_endofpacket,
  output logic [NUM_PORTS-1:0]                    in_ready,
  input  logic [NUM_PORTS-1:0]                    port_swap,
  output logic [DATA_BYTES*8-1:0]                 out_data,
  output logic [$clog2(DATA_BYTES)-1:0]           out_empty,
  output logic                                    out_valid,
  output logic                                    out_startofpacket,
  output logic                                    out_endofpacket,
  input  logic                                    out_ready,
  output logic [1:0]                              csr_address,
  output logic                                    csr_write,
  output logic [31:0]                             csr_writedata,
  output logic                                    csr_read,
  input  logic                                    csr_waitrequest,
  output logic                                    grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]            grant_id,
  output logic                                    cur_swap,
  output logic                                    proto_err
);
  localparam int DW = DATA_BYTES * 8;
  localparam int EW = $clog2(DATA_BYTES);
  localparam int W  = $clog2(NUM_PORTS);
  sched_state_t   state, state_d;
  logic [W-1:0]   gid, gid_d, rr_ptr, rr_d, win_id;
  logic           cur_d, tgt_swap, tgt_d, win_any;
  logic [NUM_PORTS-1:0] eligible, orphan, win_gnt;
  assign eligible = in_valid & in_startofpacket;
  assign orphan   = in_valid & ~in_startofpacket;
  assign csr_read = 1'b0;
  assign grant_id = grant_valid ? gid : '0;
  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req    (eligible),
    .ptr    (rr_ptr),
    .gnt    (win_gnt),
    .gnt_id (win_id),
    .any    (win_any)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gid      <= '0;
      rr_ptr   <= '0;
      cur_swap <= 1'b0;
      tgt_swap <= 1'b0;
    end else begin
      state    <= state_d;
      gid      <= gid_d;
      rr_ptr   <= rr_d;
      cur_swap <= cur_d;
      tgt_swap <= tgt_d;
    end
  end
  // Orphan drops are gated by reset_n so nothing is acknowledged while in reset.
  always_comb begin
    state_d           = state;
    gid_d             = gid;
    rr_d              = rr_ptr;
    cur_d             = cur_swap;
    tgt_d             = tgt_swap;
    out_data          = '0;
    out_empty         = '0;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    in_ready          = '0;
    csr_write         = 1'b0;
    csr_address       = CSR_ADDR_CTRL;
    csr_writedata     = '0;
    proto_err         = 1'b0;
    grant_valid       = state != IDLE;
    case (state)
      IDLE: begin
        in_ready  = orphan & {NUM_PORTS{reset_n}};
        proto_err = reset_n & |orphan;
        if (win_any) begin
          gid_d   = win_id;
          tgt_d   = |(win_gnt & port_swap);
          state_d = (|(win_gnt & port_swap)) == cur_swap ? PASS : CFG;
        end
      end
      CFG: begin
        csr_write                        = 1'b1;
        csr_writedata[CSR_CTRL_SWAP_BIT] = tgt_swap;
        cur_d   = csr_waitrequest ? cur_swap : tgt_swap;
        state_d = csr_waitrequest ? CFG : PASS;
      end
      PASS: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (W'(p) == gid) begin
            out_data          = in_data[p*DW +: DW];
            out_empty         = in_empty[p*EW +: EW];
            out_valid         = in_valid[p];
            out_startofpacket = in_startofpacket[p];
            out_endofpacket   = in_endofpacket[p];
            in_ready[p]       = out_ready;
          end
        end
        if (out_valid && out_ready && out_endofpacket) begin
          state_d = IDLE;
          rr_d    = (gid == W'(NUM_PORTS-1)) ? '0 : gid + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_endian_swapper_scheduler.sv
// tb_endian_swapper_scheduler: scoreboard bench for the round-robin swapper scheduler.
module tb_endian_swapper_scheduler;
  localparam int NP = 4, DW = 64, E = 3, W = 2;
  typedef struct packed {logic [DW-1:0] data; logic [E-1:0] empty; logic sop; logic eop;} beat_t;
  typedef struct packed {beat_t b; logic [W-1:0] port;} exp_t;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP*E-1:0]  in_empty = '0;
  logic [NP-1:0]    in_valid = '0, in_startofpacket = '0, in_endofpacket = '0, in_ready, port_swap = '0;
  logic [DW-1:0]    out_data;
  logic [E-1:0]     out_empty;
  logic             out_valid, out_startofpacket, out_endofpacket, out_ready = 1'b1;
  logic [1:0]       csr_address;
  logic             csr_write, csr_read, csr_waitrequest = 1'b0;
  logic [31:0]      csr_writedata, last_wd = '0;
  logic             grant_valid, cur_swap, proto_err, wd_unstable = 1'b0;
  logic [W-1:0]     grant_id;
  logic [NP-1:0]    hs = '0;
  beat_t src_q[NP][$];
  exp_t  sb[$];
  int checks = 0, errors = 0, csr_cnt = 0, wr_hold = 0, perr_cnt = 0;

  endian_swapper_scheduler #(.NUM_PORTS(NP), .DATA_BYTES(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_empty(in_empty), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_ready(in_ready),
    .port_swap(port_swap), .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_ready(out_ready),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_read(csr_read),
    .csr_waitrequest(csr_waitrequest), .grant_valid(grant_valid), .grant_id(grant_id),
    .cur_swap(cur_swap), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic void drive_src();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      b = (src_q[p].size() != 0) ? src_q[p][0] : '0;
      in_valid[p]            = src_q[p].size() != 0;
      in_data[p*DW +: DW]    = b.data;
      in_empty[p*E +: E]     = b.empty;
      in_startofpacket[p]    = b.sop;
      in_endofpacket[p]      = b.eop;
    end
  endfunction

  function automatic bit drained();
    int n = 0;
    for (int p = 0; p < NP; p++) n += src_q[p].size();
    return n == 0 && sb.size() == 0 && !grant_valid;
  endfunction

  // Sources: handshakes seen before the edge retire the front beat just after it.
  always @(negedge clk) hs = in_valid & in_ready;
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) if (hs[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
    drive_src();
    csr_waitrequest = csr_cnt < wr_hold;
  end

  // Monitor: CSR write fields, proto_err pulses, and output beats against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (proto_err) perr_cnt++;
    if (csr_write) begin
      csr_cnt++;
      checks++;
      if ({csr_address, csr_read} !== 3'b000) begin
        errors++;
        $display("FAIL csr_fields: got addr=%0d read=%b, want addr=0 read=0", csr_address, csr_read);
      end
      if (csr_cnt > 1 && csr_writedata !== last_wd) wd_unstable = 1'b1;
      last_wd = csr_writedata;
    end
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h port=%0d, want no beat", out_data, grant_id);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_empty, out_startofpacket, out_endofpacket, grant_id} !== e) begin
          errors++;
          $display("FAIL beat: got data=%h empty=%0d sop=%b eop=%b port=%0d, want data=%h empty=%0d sop=%b eop=%b port=%0d",
                   out_data, out_empty, out_startofpacket, out_endofpacket, grant_id,
                   e.b.data, e.b.empty, e.b.sop, e.b.eop, e.port);
        end
      end
    end
  end

  task automatic add_pkt(input int p, input int n, input logic swap);
    beat_t b;
    exp_t  e;
    port_swap[p] = swap;
    for (int i = 0; i < n; i++) begin
      b.data  = {$urandom(), $urandom()};
      b.empty = (i == n - 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      b.sop   = i == 0;
      b.eop   = i == n - 1;
      src_q[p].push_back(b);
      e.b    = b;
      e.port = W'(p);
      sb.push_back(e);
    end
  endtask

  task automatic add_orphan(input int p);
    beat_t b;
    b.data  = {$urandom(), $urandom()};
    b.empty = '0;
    b.sop   = 1'b0;
    b.eop   = 1'b0;
    src_q[p].push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !drained()) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: got not drained after %0d cycles, want drained", budget);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    add_orphan(0);
    drive_src();
    #11;
    checks += 3;
    if ({out_valid, out_startofpacket, out_endofpacket, out_data, out_empty} !== '0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b data=%h, want all 0", out_valid, out_data);
    end
    if ({in_ready, proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b proto_err=%b, want 0", in_ready, proto_err);
    end
    if ({csr_write, csr_read, grant_valid, grant_id, cur_swap} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got csr_write=%b gv=%b gid=%0d cur_swap=%b, want 0", csr_write, grant_valid, grant_id, cur_swap);
    end
    perr_cnt = 0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    wait_idle(10);
    checks++;
    if (perr_cnt !== 1) begin
      errors++;
      $display("FAIL reset_orphan: got %0d proto_err pulses, want 1", perr_cnt);
    end
  endtask

  task automatic test_basic();
    @(posedge clk);
    #2 csr_cnt = 0;
    add_pkt(2, 3, 1'b0);
    drive_src();
    @(negedge clk);
    checks++;
    if ({out_valid, grant_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_bubble: got out_valid=%b grant_valid=%b, want 0 0", out_valid, grant_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_startofpacket, grant_valid, grant_id} !== {3'b111, 2'd2}) begin
      errors++;
      $display("FAIL basic_first: got valid=%b sop=%b gv=%b gid=%0d, want 1 1 1 2", out_valid, out_startofpacket, grant_valid, grant_id);
    end
    wait_idle(30);
    checks += 2;
    if (csr_cnt !== 0) begin
      errors++;
      $display("FAIL basic_csr: got %0d csr writes, want 0", csr_cnt);
    end
    if (dut.rr_ptr !== 2'd3) begin
      errors++;
      $display("FAIL basic_rr_ptr: got %0d, want 3", dut.rr_ptr);
    end
  endtask

  task automatic test_mode_change();
    @(posedge clk);
    #2 csr_cnt = 0;
    wr_hold = 4;
    wd_unstable = 1'b0;
    csr_waitrequest = 1'b1;
    add_pkt(1, 2, 1'b1);
    drive_src();
    wait_idle(40);
    wr_hold = 0;
    checks += 3;
    if (csr_cnt !== 5) begin
      errors++;
      $display("FAIL mode_write_len: got %0d csr_write cycles, want 5", csr_cnt);
    end
    if ({wd_unstable, last_wd} !== {1'b0, 32'h1}) begin
      errors++;
      $display("FAIL mode_wdata: got wdata=%h unstable=%b, want 00000001 stable", last_wd, wd_unstable);
    end
    if (cur_swap !== 1'b1) begin
      errors++;
      $display("FAIL mode_cur_swap: got %b, want 1", cur_swap);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    @(posedge clk);
    #2 csr_cnt = 0;
    for (int r = 0; r < 3; r++) for (int p = 0; p < NP; p++) add_pkt(p, 1, 1'b0);
    drive_src();
    wait_idle(100);
    checks++;
    if (csr_cnt !== 0) begin
      errors++;
      $display("FAIL rr_csr: got %0d csr writes, want 0", csr_cnt);
    end
  endtask

  task automatic test_orphan();
    @(posedge clk);
    #2 perr_cnt = 0;
    add_orphan(0);
    drive_src();
    @(negedge clk);
    checks++;
    if ({in_ready, proto_err, out_valid} !== {4'b0001, 2'b10}) begin
      errors++;
      $display("FAIL orphan_drop: got in_ready=%b proto_err=%b out_valid=%b, want 0001 1 0", in_ready, proto_err, out_valid);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, proto_err, perr_cnt == 1} !== {4'b0000, 2'b01}) begin
      errors++;
      $display("FAIL orphan_after: got in_ready=%b proto_err=%b pulses=%0d, want 0000 0 1", in_ready, proto_err, perr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    bit done = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    add_pkt(3, 4, 1'b0);
    drive_src();
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (grant_valid && !csr_write) begin
        checks++;
        if (in_ready !== {out_ready, 3'b000}) begin
          errors++;
          $display("FAIL bp_ready: got in_ready=%b, want %b", in_ready, {out_ready, 3'b000});
        end
      end
      if (out_valid && out_ready) acc++;
      done = acc > 0 && !grant_valid;
      @(posedge clk);
      #1 out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    checks++;
    if ({acc == 4, done, sb.size() == 0} !== 3'b111) begin
      errors++;
      $display("FAIL bp_count: got %0d beats done=%b left=%0d, want 4 beats done=1 left=0", acc, done, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    @(posedge clk);
    #2 add_pkt(1, 4, 1'b0);
    drive_src();
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = out_valid && !out_startofpacket;
    end
    #2 reset_n = 1'b0;
    #1;
    checks += 2;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_seen: got no beat 2, want beat 2 presented");
    end
    if ({out_valid, in_ready, grant_valid, csr_write, proto_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_out: got out_valid=%b in_ready=%b gv=%b, want 0", out_valid, in_ready, grant_valid);
    end
    sb.delete();
    perr_cnt = 0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({perr_cnt == 2, src_q[1].size() == 0} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_orphans: got %0d pulses, %0d beats left, want 2 pulses 0 left", perr_cnt, src_q[1].size());
    end
    @(posedge clk);
    #2 add_pkt(1, 2, 1'b0);
    drive_src();
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode_change();
    test_round_robin();
    test_orphan();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/endian_swapper_scheduler.md
# endian_swapper_scheduler

Packet-atomic round-robin scheduler that shares one `endian_swapper_sv` instance between `NUM_PORTS` Avalon-ST requesters. Before granting a port whose byteswap mode differs from the swapper's current mode, it reprograms the swapper through its Avalon-MM CSR port. It then forwards the granted packet beat-for-beat. It sits directly upstream of the swapper; its stream output and CSR master connect straight to it.

## Interface
- `NUM_PORTS`, 4: number of requesting streams, 2..8.
- `DATA_BYTES`, 8: beat width in bytes; must match the swapper.
- `clk` in, 1: single clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `in_data` in, NUM_PORTS*DATA_BYTES*8: packed per-port data; port p occupies slice p.
- `in_empty` in, NUM_PORTS*$clog2(DATA_BYTES): packed per-port empty.
- `in_valid`, `in_startofpacket`, `in_endofpacket` in, NUM_PORTS: per-port strobes.
- `in_ready` out, NUM_PORTS: per-port ready.
- `port_swap` in, NUM_PORTS: required byteswap mode per port; sampled at arbitration.
- `out_data`, `out_empty`, `out_valid`, `out_startofpacket`, `out_endofpacket` out: stream toward `stream_in_*` on the swapper.
- `out_ready` in, 1: from the swapper's `stream_in_ready`.
- `csr_address` out, 2; `csr_write` out, 1; `csr_writedata` out, 32; `csr_read` out, 1: CSR master toward the swapper.
- `csr_waitrequest` in, 1: from the swapper.
- `grant_valid` out, 1: a packet is in flight.
- `grant_id` out, $clog2(NUM_PORTS): index of the granted port.
- `cur_swap` out, 1: mode last written to the swapper.
- `proto_err` out, 1: one-cycle pulse when an orphan beat is discarded.

## Operation
- FSM states: IDLE, CFG, PASS.
- IDLE: eligible ports are those with `in_valid & in_startofpacket`. The winner is the first eligible port at or after the round-robin pointer `rr_ptr`, wrapping.
  - Winner with `port_swap[w]==cur_swap`: go to PASS.
  - Otherwise: go to CFG.
  - In both cases register `grant_id=w`.
- IDLE, orphan beats: any port with `in_valid & ~in_startofpacket` gets `in_ready=1` for that cycle. The beat is dropped and `proto_err` pulses, once per dropped beat.
- CFG: hold `csr_write=1`, `csr_address=0`, `csr_writedata={31'b0,port_swap[grant_id]}`. These stay constant until a cycle with `!csr_waitrequest`. In that cycle `cur_swap` takes the new value, and the next state is PASS.
- PASS: combinational mux of the granted port onto `out_*`.
  - `in_ready[grant_id]=out_ready`; all other `in_ready` bits are 0.
  - On `out_valid & out_ready & out_endofpacket`: go to IDLE and set `rr_ptr=grant_id+1` (mod NUM_PORTS).
- `csr_read` is tied to 0. The scheduler never reads the swapper's packet count.
- `port_swap` changes during CFG or PASS have no effect until the next arbitration.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `cur_swap=0` (matches the swapper's reset mode).
- Outputs during reset: all `out_*`, `in_ready`, `csr_write`, `csr_read`, `grant_valid`, `grant_id`, `proto_err` are 0.
- Arbitration bubble: exactly 1 cycle in IDLE. The first beat can be presented in the cycle after the request was first seen.
- Mode change: at least 1 CFG cycle, plus one cycle per waitrequest-high cycle. The swapper holds waitrequest while its previous packet is flushing; the scheduler waits, never aborts.
- PASS adds 0 latency. Valid/ready follow readyLatency 0.
- `grant_valid=1` in CFG and PASS.
- Single-beat packet (sop & eop): one PASS cycle, then IDLE.
- Simultaneous requests: the winner is the lowest index at or after `rr_ptr`. A port that just finished has lowest priority on the next arbitration.
- Reset asserted mid-packet: all outputs drop immediately and the FSM returns to IDLE. The remainder of the interrupted packet is treated as orphan beats.
- No eligible ports: stay in IDLE, all outputs 0.

## Structure
- Package `endian_swapper_pkg`:
  - state enum `sched_state_t` {IDLE, CFG, PASS}.
  - CSR address constants `CSR_ADDR_CTRL=2'd0`, `CSR_ADDR_PKT_COUNT=2'd1`.
  - `CSR_CTRL_SWAP_BIT=0`.
- One sub-module `rr_arbiter` (parameter `N`): inputs `req[N]` and `ptr`; outputs one-hot `gnt`, index `gnt_id`, `any`. Purely combinational.
- Top level holds the FSM, the registers, and the stream mux.

## Test plan
- Reset, then port 2 sends a 3-beat packet with `port_swap[2]=0` -> no `csr_write`. PASS starts 1 cycle after the request. `grant_id=2`. Output data equals input. `rr_ptr=3` afterwards.
- Port 1 has `port_swap=1`, and the swapper holds `csr_waitrequest` high for 4 cycles -> `csr_write` held 5 cycles with `csr_writedata=32'h1`, address 0. `cur_swap=1`. Output bytes reversed end-to-end (e.g. 64'h0011223344556677 -> 64'h7766554433221100).
- All 4 ports request continuously with single-beat packets -> grant order 0,1,2,3,0… with no port starved.
- Port 0 presents a beat with `valid=1`, `sop=0` in IDLE -> `in_ready[0]=1` for one cycle, `proto_err` pulses once, nothing on `out_*`.
- `out_ready` toggles 1,0,1,0 during a 4-beat packet -> `in_ready[grant_id]` mirrors it, no beat is lost or duplicated, and the packet finishes on the 4th accepted beat.
- `reset_n` pulsed low on beat 2 of 4 -> outputs 0 asynchronously. Beats 3 and 4 are discarded as orphans with 2 `proto_err` pulses. The next sop packet is arbitrated normally.
